tdm_frame_sequencer: RTL and testbench

// - Upstream feeder for the 1-to-8 demux. Takes a serial TDM bitstream with a frame-start strobe.
// - Drives the demux select and data inputs, one channel per accepted bit.
// - Also assembles each completed 8-channel frame into a parallel word with a 1-cycle valid pulse.
// - Detects frame-sync slips and flags them.

---
 rtl/tdm_pkg.sv | 23 ++
 rtl/tdm_frame_sequencer_if.sv | 36 +++
 rtl/mod_n_counter.sv | 42 ++++
 rtl/tdm_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_tdm_frame_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the TDM frame sequencer.
//   tdm_state_t  : sequencer FSM state (IDLE waiting for frame start, RUN
//                  walking through the channels of a frame)
//   N_CH_DEFAULT : default number of channels per frame
//   sel_width()  : select/counter width for a given channel count
// ---------------------------------------------------------------------------
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tdm_state_t;

   localparam int N_CH_DEFAULT = 8;

   // Width needed to address n channels; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tdm_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// tdm_frame_sequencer_if
// Bundles the serial TDM input and the demux/frame outputs of the sequencer.
//   EN, SYNC, DIN           : serial side (bit strobe, frame start, data bit)
//   SEL, D                  : demux select and data
//   FRAME, FRAME_VALID, ERR : assembled frame, its update pulse, sync-slip pulse
// Modports:
//   master : the source of the bitstream / consumer of the results
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface tdm_frame_sequencer_if import tdm_pkg::*; #(
   parameter int N_CH = N_CH_DEFAULT
) ();

   localparam int SEL_W = sel_width(N_CH);

   logic             EN;
   logic             SYNC;
   logic             DIN;
   logic [SEL_W-1:0] SEL;
   logic             D;
   logic [N_CH-1:0]  FRAME;
   logic             FRAME_VALID;
   logic             ERR;

   modport master (
      output EN, SYNC, DIN,
      input  SEL, D, FRAME, FRAME_VALID, ERR
   );

   modport slave (
      input  EN, SYNC, DIN,
      output SEL, D, FRAME, FRAME_VALID, ERR
   );

endinterface

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// mod_n_counter
// Modulo-N up counter with synchronous load. Load wins over increment.
//   CLK, N_RESET : clock, asynchronous active-low reset (count returns to 0)
//   load         : load load_val on the next edge
//   inc          : advance by one, wrapping from N-1 to 0
//   load_val     : value taken on load
//   cnt          : current count
//   term         : high while cnt == N-1
// ---------------------------------------------------------------------------
module mod_n_counter import tdm_pkg::*; #(
   parameter  int N = N_CH_DEFAULT,
   localparam int W = sel_width(N)
) (
   input  logic         CLK,
   input  logic         N_RESET,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         term
);

   logic [W-1:0] cnt_r;

   assign term = (cnt_r == W'(N - 1));
   assign cnt  = cnt_r;

   // Count register: load, wrap-around increment, or hold.
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (inc) begin
         cnt_r <= term ? W'(0) : cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/tdm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tdm_frame_sequencer
// Turns a serial TDM bitstream into demux select/data (one channel per
// accepted bit), assembles each complete frame into a parallel word and
// flags frame-sync slips.
//   CLK     : system clock, rising edge
//   N_RESET : asynchronous active-low reset
//   bus     : slave side of tdm_frame_sequencer_if
//             in : EN (bit accept), SYNC (channel 0 marker), DIN
//             out: SEL, D (registered demux drive), FRAME, FRAME_VALID, ERR
// The channel counter holds the next expected channel; a value of 0 while
// in RUN means a complete frame has just been taken and SYNC is due.
// ---------------------------------------------------------------------------
module tdm_frame_sequencer import tdm_pkg::*; #(
   parameter  int N_CH  = N_CH_DEFAULT,
   localparam int SEL_W = sel_width(N_CH)
) (
   input logic                    CLK,
   input logic                    N_RESET,
   tdm_frame_sequencer_if.slave   bus
);

   tdm_state_t       state_r;
   tdm_state_t       state_nxt_s;

   logic [SEL_W-1:0] cnt_s;
   logic             term_s;
   logic             cnt_load_s;
   logic             cnt_inc_s;
   logic [SEL_W-1:0] load_val_s;

   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_nxt_s;
   logic             d_r;
   logic             d_nxt_s;
   // Channels 0..N_CH-2; the last channel goes straight into the frame word.
   logic [N_CH-2:0]  shadow_r;
   logic [N_CH-2:0]  shadow_nxt_s;
   logic [N_CH-1:0]  frame_r;
   logic [N_CH-1:0]  frame_nxt_s;
   logic             frame_valid_r;
   logic             frame_valid_nxt_s;
   logic             err_r;
   logic             err_nxt_s;

   mod_n_counter #(.N(N_CH)) u_cnt (
      .CLK      (CLK),
      .N_RESET  (N_RESET),
      .load     (cnt_load_s),
      .inc      (cnt_inc_s),
      .load_val (load_val_s),
      .cnt      (cnt_s),
      .term     (term_s)
   );

   // FSM state register.
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, counter control and next values of all output registers.
   always_comb begin
      state_nxt_s       = state_r;
      sel_nxt_s         = sel_r;
      d_nxt_s           = 1'b0;
      shadow_nxt_s      = shadow_r;
      frame_nxt_s       = frame_r;
      frame_valid_nxt_s = 1'b0;
      err_nxt_s         = 1'b0;
      cnt_load_s        = 1'b0;
      cnt_inc_s         = 1'b0;
      load_val_s        = SEL_W'(0);

      if (bus.EN) begin
         case (state_r)
            IDLE: begin
               if (bus.SYNC) begin
                  state_nxt_s     = RUN;
                  sel_nxt_s       = SEL_W'(0);
                  d_nxt_s         = bus.DIN;
                  shadow_nxt_s[0] = bus.DIN;
                  cnt_load_s      = 1'b1;
                  load_val_s      = SEL_W'(1);
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (bus.SYNC) begin
                  // SYNC always restarts at channel 0; it is a slip unless
                  // channel 0 was the one expected (partial frame dropped).
                  err_nxt_s       = (cnt_s != SEL_W'(0));
                  sel_nxt_s       = SEL_W'(0);
                  d_nxt_s         = bus.DIN;
                  shadow_nxt_s[0] = bus.DIN;
                  cnt_load_s      = 1'b1;
                  load_val_s      = SEL_W'(1);
               end else if (cnt_s == SEL_W'(0)) begin
                  // Frame boundary without SYNC: lost alignment.
                  err_nxt_s   = 1'b1;
                  state_nxt_s = IDLE;
                  cnt_load_s  = 1'b1;
                  load_val_s  = SEL_W'(0);
               end else begin
                  sel_nxt_s = cnt_s;
                  d_nxt_s   = bus.DIN;
                  cnt_inc_s = 1'b1;
                  if (term_s) begin
                     frame_nxt_s       = {bus.DIN, shadow_r};
                     frame_valid_nxt_s = 1'b1;
                  end else begin
                     shadow_nxt_s[cnt_s] = bus.DIN;
                  end
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_load_s  = 1'b1;
               load_val_s  = SEL_W'(0);
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Output, shadow and frame registers.
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         sel_r         <= '0;
         d_r           <= 1'b0;
         shadow_r      <= '0;
         frame_r       <= '0;
         frame_valid_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         sel_r         <= sel_nxt_s;
         d_r           <= d_nxt_s;
         shadow_r      <= shadow_nxt_s;
         frame_r       <= frame_nxt_s;
         frame_valid_r <= frame_valid_nxt_s;
         err_r         <= err_nxt_s;
      end
   end

   assign bus.SEL         = sel_r;
   assign bus.D           = d_r;
   assign bus.FRAME       = frame_r;
   assign bus.FRAME_VALID = frame_valid_r;
   assign bus.ERR         = err_r;

endmodule

// File: tb/tb_tdm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tdm_frame_sequencer
// Drives tdm_frame_sequencer with directed frames and a random bitstream,
// feeds SEL/D into a 1-to-8 demux and compares everything against a
// queue-based model of the frame rules.
// ---------------------------------------------------------------------------
module tb_tdm_frame_sequencer;

   localparam int N = 8;

   logic CLK;
   logic N_RESET;

   tdm_frame_sequencer_if #(.N_CH(N)) bus ();

   tdm_frame_sequencer #(.N_CH(N)) dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .bus     (bus)
   );

   // 1-to-8 demux driven by the sequencer.
   logic [N-1:0] demux_out;
   assign demux_out = bus.D ? (8'd1 << bus.SEL) : 8'd0;

   // Free-running clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_vec  = 0;
   int n_cmp  = 0;
   int n_fail = 0;
   int fv_seen = 0;
   logic [N-1:0] acc_dmx;

   // Reference model: bits of the current frame in arrival order.
   bit           in_frame;
   bit           q[$];
   logic [2:0]   exp_sel;
   bit           exp_d;
   logic [N-1:0] exp_frame;
   bit           exp_fv;
   bit           exp_err;

   task automatic model_reset();
      in_frame  = 1'b0;
      q.delete();
      exp_sel   = 3'd0;
      exp_d     = 1'b0;
      exp_frame = 8'd0;
      exp_fv    = 1'b0;
      exp_err   = 1'b0;
   endtask

   task automatic model_accept(input bit sync, input bit din);
      exp_fv  = 1'b0;
      exp_err = 1'b0;
      if (!in_frame) begin
         if (sync) begin
            q.delete(); q.push_back(din);
            in_frame = 1'b1; exp_sel = 3'd0; exp_d = din;
         end else begin
            exp_d = 1'b0;
         end
      end else if (sync) begin
         exp_err = (q.size() != N);
         q.delete(); q.push_back(din);
         exp_sel = 3'd0; exp_d = din;
      end else if (q.size() == N) begin
         exp_err = 1'b1; in_frame = 1'b0; exp_d = 1'b0;
      end else begin
         exp_sel = 3'(q.size());
         exp_d   = din;
         q.push_back(din);
         if (q.size() == N) begin
            for (int i = 0; i < N; i++) exp_frame[i] = q[i];
            exp_fv = 1'b1;
         end
      end
   endtask

   task automatic model_idle();
      exp_d   = 1'b0;
      exp_fv  = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] exp_dmx;
      exp_dmx = exp_d ? (8'd1 << exp_sel) : 8'd0;
      check({tag, ".sel"},   32'(bus.SEL),         32'(exp_sel));
      check({tag, ".d"},     32'(bus.D),           32'(exp_d));
      check({tag, ".frame"}, 32'(bus.FRAME),       32'(exp_frame));
      check({tag, ".fv"},    32'(bus.FRAME_VALID), 32'(exp_fv));
      check({tag, ".err"},   32'(bus.ERR),         32'(exp_err));
      check({tag, ".demux"}, 32'(demux_out),       32'(exp_dmx));
      check({tag, ".excl"},  32'(bus.FRAME_VALID & bus.ERR), 32'd0);
   endtask

   task automatic step(input string tag, input bit en, input bit sync, input bit din);
      @(negedge CLK);
      bus.EN   = en;
      bus.SYNC = sync;
      bus.DIN  = din;
      @(posedge CLK);
      if (en) model_accept(sync, din);
      else    model_idle();
      #1;
      n_vec++;
      if (bus.FRAME_VALID === 1'b1) fv_seen++;
      acc_dmx = acc_dmx | demux_out;
      check_all(tag);
   endtask

   task automatic send_bits(input string tag, input logic [7:0] v, input int from,
                            input int to, input bit sync_first);
      for (int i = from; i <= to; i++) step(tag, 1'b1, sync_first && (i == from), v[i]);
   endtask

   // Directed scenarios followed by a random bitstream.
   initial begin
      int fv0;
      bit exp_ch0;
      N_RESET  = 1'b0;
      bus.EN   = 1'b0;
      bus.SYNC = 1'b0;
      bus.DIN  = 1'b0;
      acc_dmx  = '0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge CLK);
      N_RESET = 1'b1;

      // Bit without SYNC while idle is ignored.
      step("idle_nosync", 1'b1, 1'b0, 1'b1);

      // Clean frame 1,0,1,1,0,0,1,0.
      acc_dmx = '0;
      fv0 = fv_seen;
      send_bits("clean", 8'b01001101, 0, 7, 1'b1);
      check("clean.frame_const", 32'(bus.FRAME), 32'h4D);
      check("clean.fv_count", 32'(fv_seen - fv0), 32'd1);
      check("clean.demux_chans", 32'(acc_dmx), 32'h4D);
      step("clean_gap", 1'b0, 1'b0, 1'b0);

      // Same frame with a 3-cycle EN gap after bit 4.
      fv0 = fv_seen;
      send_bits("engap", 8'b01001101, 0, 4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step("engap_off", 1'b0, 1'b1, 1'b1);
         check("engap.sel_hold", 32'(bus.SEL), 32'd4);
         check("engap.d_zero", 32'(bus.D), 32'd0);
      end
      send_bits("engap", 8'b01001101, 5, 7, 1'b0);
      check("engap.frame_const", 32'(bus.FRAME), 32'h4D);
      check("engap.fv_count", 32'(fv_seen - fv0), 32'd1);

      // Early sync at bit 5 with DIN=1, then a full frame from there.
      fv0 = fv_seen;
      send_bits("early", 8'hC3, 0, 4, 1'b1);
      step("early_sync", 1'b1, 1'b1, 1'b1);
      check("early.err", 32'(bus.ERR), 32'd1);
      check("early.sel", 32'(bus.SEL), 32'd0);
      check("early.d", 32'(bus.D), 32'd1);
      check("early.frame_kept", 32'(bus.FRAME), 32'h4D);
      send_bits("early_rest", 8'h5B, 1, 7, 1'b0);
      check("early.frame_new", 32'(bus.FRAME), 32'h5B);
      check("early.fv_count", 32'(fv_seen - fv0), 32'd1);

      // Missing sync on the 9th bit, then clean restart.
      send_bits("miss", 8'h3C, 0, 7, 1'b1);
      step("miss_9th", 1'b1, 1'b0, 1'b1);
      check("miss.err", 32'(bus.ERR), 32'd1);
      check("miss.d", 32'(bus.D), 32'd0);
      check("miss.fv", 32'(bus.FRAME_VALID), 32'd0);
      step("miss_idle", 1'b1, 1'b0, 1'b1);
      send_bits("miss_restart", 8'h96, 0, 7, 1'b1);
      check("miss.frame", 32'(bus.FRAME), 32'h96);

      // Back-to-back frames, no bubbles.
      fv0 = fv_seen;
      send_bits("b2b", 8'hA5, 0, 7, 1'b1);
      check("b2b.frame_a5", 32'(bus.FRAME), 32'hA5);
      send_bits("b2b", 8'hFF, 0, 7, 1'b1);
      check("b2b.frame_ff", 32'(bus.FRAME), 32'hFF);
      send_bits("b2b", 8'h00, 0, 7, 1'b1);
      check("b2b.frame_00", 32'(bus.FRAME), 32'h00);
      check("b2b.fv_count", 32'(fv_seen - fv0), 32'd3);

      // Asynchronous reset in the middle of a frame.
      send_bits("rst_pre", 8'hE7, 0, 7, 1'b1);
      send_bits("rst_part", 8'h0F, 0, 2, 1'b1);
      #2;
      N_RESET = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge CLK);
      N_RESET = 1'b1;
      step("rst_ignored", 1'b1, 1'b0, 1'b1);
      send_bits("rst_restart", 8'h81, 0, 7, 1'b1);
      check("rst.frame", 32'(bus.FRAME), 32'h81);

      // Random stream, SYNC biased toward the expected frame starts.
      for (int i = 0; i < 800; i++) begin
         exp_ch0 = !in_frame || (q.size() == N);
         step("rand", ($urandom_range(0, 3) != 0),
              exp_ch0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0),
              1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
